// File: rtl/regfile_arb_pkg.sv
// Shared constants for the register-file write arbiter.
// Used by regfile_arb_grant and regfile_write_arbiter.
package regfile_arb_pkg;

    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned REG_IDX_W    = $clog2(NUM_REGS);
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // Requester identifiers: port 0 is ALU/load writeback, port 1 is multdiv.
    localparam logic PORT_ALU = 1'b0;
    localparam logic PORT_MD  = 1'b1;

    localparam int unsigned STARVE_CNT_W = 4;
    localparam int unsigned STALL_CNT_W  = 16;

endpackage

// File: rtl/regfile_arb_grant.sv
// Combinational grant/ready logic for the two writeback requesters.
// Ports:
//   p0_valid, p1_valid : request valids
//   hold               : suppresses all grants (freeze or reset)
//   starve             : port 1 has lost STARVE_LIMIT consecutive cycles
//   p0_grant_c         : port 0 wins this cycle
//   p1_grant_c         : port 1 wins this cycle
module regfile_arb_grant (
    input  logic p0_valid,
    input  logic p1_valid,
    input  logic hold,
    input  logic starve,
    output logic p0_grant_c,
    output logic p1_grant_c
);

    // Port 0 has fixed priority except when port 1 is starving.
    always_comb begin
        p0_grant_c = 1'b0;
        p1_grant_c = 1'b0;
        if (!hold) begin
            if (p1_valid && (!p0_valid || starve)) begin
                p1_grant_c = 1'b1;
            end else if (p0_valid) begin
                p0_grant_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between ALU/load writeback
// (port 0) and multdiv completion (port 1). One grant per cycle; the winning
// write is registered and strobed into the register file on the next cycle.
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-low reset
//   p0_* / p1_*             : valid/ready write request ports (ready combinational)
//   wr_hold                 : freeze, no grants while high
//   ctrl_writeEnable        : registered write strobe (never for r0)
//   ctrl_writeReg           : registered write index
//   data_writeReg           : registered write data
//   stall_count             : saturating count of stalled-request cycles,
//                             present only when REGFILE_ARB_STALL_CNT_EN is defined
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned DATA_W       = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 p0_valid,
    input  logic [REG_IDX_W-1:0] p0_reg,
    input  logic [DATA_W-1:0]    p0_data,
    output logic                 p0_ready,
    input  logic                 p1_valid,
    input  logic [REG_IDX_W-1:0] p1_reg,
    input  logic [DATA_W-1:0]    p1_data,
    output logic                 p1_ready,
    input  logic                 wr_hold,
`ifdef REGFILE_ARB_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_count,
`endif
    output logic                 ctrl_writeEnable,
    output logic [REG_IDX_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0]    data_writeReg
);

    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    we_q, we_d;
    logic [REG_IDX_W-1:0]    wreg_q, wreg_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;

    logic p0_grant, p1_grant, starve, sel_port;
    logic [REG_IDX_W-1:0] win_reg;
    logic [DATA_W-1:0]    win_data;

    assign starve = (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT));

    // Reset masks readiness so nothing is accepted while in reset.
    regfile_arb_grant u_grant (
        .p0_valid   (p0_valid),
        .p1_valid   (p1_valid),
        .hold       (wr_hold | ~reset),
        .starve     (starve),
        .p0_grant_c (p0_grant),
        .p1_grant_c (p1_grant)
    );

    assign p0_ready = p0_grant;
    assign p1_ready = p1_grant;

    assign sel_port = p1_grant ? PORT_MD : PORT_ALU;
    assign win_reg  = (sel_port == PORT_MD) ? p1_reg  : p0_reg;
    assign win_data = (sel_port == PORT_MD) ? p1_data : p0_data;

    // Starvation counter: frozen under hold, cleared once port 1 wins or goes idle.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!wr_hold) begin
            if (!p1_valid || p1_grant) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q < STARVE_CNT_W'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
            end
        end
    end

    // Output stage: index/data hold when idle, r0 writes never strobe.
    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (p0_grant || p1_grant) begin
            we_d    = (win_reg != REG_ZERO);
            wreg_d  = win_reg;
            wdata_d = win_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_cnt_q <= '0;
            we_q         <= 1'b0;
            wreg_q       <= '0;
            wdata_q      <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            we_q         <= we_d;
            wreg_q       <= wreg_d;
            wdata_q      <= wdata_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;

`ifdef REGFILE_ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    // Any valid request left waiting this cycle counts as a stall, saturating.
    always_comb begin
        stall_count_d = stall_count_q;
        if (((p0_valid && !p0_grant) || (p1_valid && !p1_grant))
            && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a behavioural model checked
// every cycle plus directed scenarios with hand-computed expectations.
module tb_regfile_write_arbiter;

    localparam int unsigned DW    = 32;
    localparam int          LIMIT = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          p0_valid, p1_valid, wr_hold;
    logic [4:0]    p0_reg, p1_reg;
    logic [DW-1:0] p0_data, p1_data;
    logic          p0_ready, p1_ready;
    logic          ctrl_writeEnable;
    logic [4:0]    ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
`ifdef REGFILE_ARB_STALL_CNT_EN
    logic [15:0]   stall_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT), .DATA_W(DW)) dut (
        .clock            (clock),
        .reset            (reset),
        .p0_valid         (p0_valid),
        .p0_reg           (p0_reg),
        .p0_data          (p0_data),
        .p0_ready         (p0_ready),
        .p1_valid         (p1_valid),
        .p1_reg           (p1_reg),
        .p1_data          (p1_data),
        .p1_ready         (p1_ready),
        .wr_hold          (wr_hold),
`ifdef REGFILE_ARB_STALL_CNT_EN
        .stall_count      (stall_count),
`endif
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          seen_edge = 1'b0;
    int          losses    = 0;      // consecutive cycles port 1 waited and lost
    logic        exp_we    = 1'b0;
    logic [4:0]  exp_reg   = '0;
    logic [31:0] exp_data  = '0;
    int          exp_stall = 0;

    always @(posedge clock) seen_edge <= 1'b1;

    always @(negedge clock) begin
        bit m0, m1;
        if (seen_edge) begin
            chk("m_we",   {31'd0, ctrl_writeEnable}, {31'd0, exp_we});
            chk("m_reg",  {27'd0, ctrl_writeReg},    {27'd0, exp_reg});
            chk("m_data", data_writeReg,             exp_data);
`ifdef REGFILE_ARB_STALL_CNT_EN
            chk("m_stall", {16'd0, stall_count}, 32'(exp_stall));
`endif
            m0 = 0; m1 = 0;
            if (reset && !wr_hold) begin
                if (p0_valid && p1_valid) begin
                    if (losses >= LIMIT) m1 = 1; else m0 = 1;
                end else begin
                    m0 = p0_valid;
                    m1 = p1_valid;
                end
            end
            chk("m_p0_ready", {31'd0, p0_ready}, {31'd0, m0});
            chk("m_p1_ready", {31'd0, p1_ready}, {31'd0, m1});

            if (!reset) begin
                exp_we = 0; exp_reg = 0; exp_data = 0; losses = 0; exp_stall = 0;
            end else begin
                if (m0) begin
                    exp_we = (p0_reg != 0); exp_reg = p0_reg; exp_data = p0_data;
                end else if (m1) begin
                    exp_we = (p1_reg != 0); exp_reg = p1_reg; exp_data = p1_data;
                end else begin
                    exp_we = 0;
                end
                if (!wr_hold) begin
                    if (!p1_valid || m1) losses = 0;
                    else if (losses < LIMIT) losses = losses + 1;
                end
                if (((p0_valid && !m0) || (p1_valid && !m1)) && exp_stall < 65535)
                    exp_stall = exp_stall + 1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic mid(); @(negedge clock); #1; endtask
    task automatic nxt(); @(posedge clock); #1; endtask

    task automatic set_p0(input logic v, input logic [4:0] r, input logic [31:0] d);
        p0_valid = v; p0_reg = r; p0_data = d;
    endtask
    task automatic set_p1(input logic v, input logic [4:0] r, input logic [31:0] d);
        p1_valid = v; p1_reg = r; p1_data = d;
    endtask

    initial begin
        reset = 1'b0; wr_hold = 1'b0;
        set_p0(1, 5'd3, 32'h1111);
        set_p1(1, 5'd4, 32'h2222);

        // Reset with both ports requesting.
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("rst_p0_ready", {31'd0, p0_ready}, 0);
            chk("rst_p1_ready", {31'd0, p1_ready}, 0);
            chk("rst_we",   {31'd0, ctrl_writeEnable}, 0);
            chk("rst_reg",  {27'd0, ctrl_writeReg}, 0);
            chk("rst_data", data_writeReg, 0);
            nxt();
        end

        // Single write to r5.
        reset = 1'b1;
        set_p0(1, 5'd5, 32'hDEADBEEF);
        set_p1(0, 5'd0, 32'h0);
        mid(); chk("single_ready", {31'd0, p0_ready}, 1); nxt();
        set_p0(0, 5'd0, 32'h0);
        mid();
        chk("single_we",   {31'd0, ctrl_writeEnable}, 1);
        chk("single_reg",  {27'd0, ctrl_writeReg}, 5);
        chk("single_data", data_writeReg, 32'hDEADBEEF);
        nxt();
        mid();
        chk("single_we_off", {31'd0, ctrl_writeEnable}, 0);
        chk("idle_reg_hold", {27'd0, ctrl_writeReg}, 5);
        nxt();

        // Write to r0: accepted, no strobe, index/data still update.
        set_p1(1, 5'd0, 32'h1234);
        mid(); chk("r0_ready", {31'd0, p1_ready}, 1); nxt();
        set_p1(0, 5'd0, 32'h0);
        mid();
        chk("r0_we",   {31'd0, ctrl_writeEnable}, 0);
        chk("r0_reg",  {27'd0, ctrl_writeReg}, 0);
        chk("r0_data", data_writeReg, 32'h1234);
        nxt();

        // Starvation: p1 loses 4 cycles, wins the 5th.
        for (int i = 0; i < 5; i++) begin
            set_p0(1, 5'(i + 1), 32'(256 + i));
            set_p1(1, 5'd7, 32'h77);
            mid();
            chk("starve_p0", {31'd0, p0_ready}, {31'd0, (i < 4)});
            chk("starve_p1", {31'd0, p1_ready}, {31'd0, (i == 4)});
            nxt();
        end
        set_p0(1, 5'd10, 32'hAA);
        set_p1(1, 5'd8, 32'h88);
        mid();
        chk("starve_we",   {31'd0, ctrl_writeEnable}, 1);
        chk("starve_reg",  {27'd0, ctrl_writeReg}, 7);
        chk("starve_data", data_writeReg, 32'h77);
        chk("starve_cleared", {31'd0, p0_ready}, 1);
        nxt();
        set_p0(0, 5'd0, 32'h0); set_p1(0, 5'd0, 32'h0);
        mid(); nxt();

        // Hold: p1 loses twice, then 5 frozen cycles, then resumes at count 2.
        set_p0(1, 5'd2, 32'h22);
        set_p1(1, 5'd3, 32'h33);
        mid(); nxt();
        mid(); nxt();
        wr_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("hold_p0", {31'd0, p0_ready}, 0);
            chk("hold_p1", {31'd0, p1_ready}, 0);
            chk("hold_we", {31'd0, ctrl_writeEnable}, {31'd0, (i == 0)});
            nxt();
        end
        wr_hold = 1'b0;
        mid(); chk("unhold_p0_first", {31'd0, p0_ready}, 1); nxt();
        mid(); chk("unhold_p0_second", {31'd0, p0_ready}, 1); nxt();
        mid(); chk("unhold_p1_starved", {31'd0, p1_ready}, 1); nxt();

        // Same target register: p0 wins first, p1's value lands last.
        set_p0(1, 5'd12, 32'hA1);
        set_p1(1, 5'd12, 32'hB2);
        mid(); chk("coll_p0", {31'd0, p0_ready}, 1); nxt();
        set_p0(0, 5'd0, 32'h0);
        mid(); chk("coll_p1", {31'd0, p1_ready}, 1); nxt();
        set_p1(0, 5'd0, 32'h0);
        mid();
        chk("coll_reg",  {27'd0, ctrl_writeReg}, 12);
        chk("coll_data", data_writeReg, 32'hB2);
        nxt();

        // Reset mid-operation clears the registered write.
        set_p0(1, 5'd9, 32'h99);
        mid(); nxt();
        set_p0(0, 5'd0, 32'h0);
        reset = 1'b0;
        mid(); chk("rstmid_pending", {31'd0, ctrl_writeEnable}, 1); nxt();
        mid();
        chk("rstmid_we",   {31'd0, ctrl_writeEnable}, 0);
        chk("rstmid_reg",  {27'd0, ctrl_writeReg}, 0);
        chk("rstmid_data", data_writeReg, 0);
        nxt();
        reset = 1'b1;

`ifdef REGFILE_ARB_STALL_CNT_EN
        // Stall counter: 10 blocked cycles, then long run to saturation.
        wr_hold = 1'b1;
        set_p1(1, 5'd6, 32'h66);
        for (int i = 0; i < 10; i++) nxt();
        mid(); chk("stall_10", {16'd0, stall_count}, 10); nxt();
        for (int i = 0; i < 70000; i++) nxt();
        mid(); chk("stall_sat", {16'd0, stall_count}, 32'hFFFF); nxt();
        wr_hold = 1'b0;
        set_p1(0, 5'd0, 32'h0);
        mid(); nxt();
`endif

        mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
